// File: rtl/me_search_window_ctrl.sv
// Search-window buffer sequencer: writes pixels column by column into a 3-column buffer and scans the oldest column(s) for the PE array.
// Latency: buffer writes follow a pixel accept by 1 cycle; reads start 1 cycle after scan_start is sampled; data is valid 1 cycle after each read.
// Backpressure: pix_ready stays low while all 3 columns are filled. Macro ME_SEARCH_SLIDE_EN scans all 3 columns as a sliding window.
module me_search_window_ctrl #(
    parameter int ROWS   = 47,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_valid,
    output logic [5:0]        scan_row,
    output logic              scan_done,
    output logic [1:0]        col_count,
    output logic              search_read,
    output logic [ADDR_W-1:0] search_read_addr,
    output logic              search_write,
    output logic [ADDR_W-1:0] search_write_addr,
    output logic [7:0]        search_write_data
);

`ifdef ME_SEARCH_SLIDE_EN
    localparam logic [1:0] SCAN_REQ     = 2'd3;
    localparam logic [1:0] LAST_COL_IDX = 2'd2;
`else
    localparam logic [1:0] SCAN_REQ     = 2'd1;
    localparam logic [1:0] LAST_COL_IDX = 2'd0;
`endif

    localparam logic [5:0]        LAST_ROW = 6'(ROWS - 1);
    localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] BASE2    = ADDR_W'(2 * ROWS);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    function automatic logic [1:0] col_inc(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // Column bases are constants, so the col*ROWS product reduces to a 3-way mux.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] c, input logic [5:0] r);
        logic [ADDR_W-1:0] base;
        case (c)
            2'd1:    base = BASE1;
            2'd2:    base = BASE2;
            default: base = '0;
        endcase
        return base + ADDR_W'(r);
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        wr_col_q, wr_col_d;
    logic [5:0]        wr_row_q, wr_row_d;
    logic [1:0]        rd_col_q, rd_col_d;
    logic [1:0]        scan_col_q, scan_col_d;
    logic [1:0]        scan_idx_q, scan_idx_d;
    logic [5:0]        rd_row_q, rd_row_d;
    logic [1:0]        col_count_q, col_count_d;
    logic              scan_busy_q, scan_busy_d;
    logic              scan_valid_q, scan_valid_d;
    logic [5:0]        scan_row_q, scan_row_d;
    logic              scan_done_q, scan_done_d;
    logic              search_read_q, search_read_d;
    logic [ADDR_W-1:0] search_read_addr_q, search_read_addr_d;
    logic              search_write_q, search_write_d;
    logic [ADDR_W-1:0] search_write_addr_q, search_write_addr_d;
    logic [7:0]        search_write_data_q, search_write_data_d;
    logic              accept, col_done, col_release;

    assign pix_ready = (col_count_q != 2'd3);

    always_comb begin
        state_d             = state_q;
        wr_col_d            = wr_col_q;
        wr_row_d            = wr_row_q;
        rd_col_d            = rd_col_q;
        scan_col_d          = scan_col_q;
        scan_idx_d          = scan_idx_q;
        rd_row_d            = rd_row_q;
        col_count_d         = col_count_q;
        scan_done_d         = 1'b0;
        search_read_d       = 1'b0;
        search_read_addr_d  = search_read_addr_q;
        search_write_d      = 1'b0;
        search_write_addr_d = search_write_addr_q;
        search_write_data_d = search_write_data_q;
        col_release         = 1'b0;

        accept   = pix_valid && pix_ready;
        col_done = accept && (wr_row_q == LAST_ROW);

        if (accept) begin
            search_write_d      = 1'b1;
            search_write_addr_d = addr_of(wr_col_q, wr_row_q);
            search_write_data_d = pix_data;
            wr_row_d            = col_done ? 6'd0 : wr_row_q + 6'd1;
            if (col_done) begin
                wr_col_d = col_inc(wr_col_q);
            end
        end

        // Buffer data lags the read strobe by one cycle; the row index rides along.
        scan_valid_d = search_read_q;
        scan_row_d   = search_read_q ? rd_row_q : 6'd0;

        case (state_q)
            IDLE: begin
                if (scan_start && (col_count_q >= SCAN_REQ)) begin
                    state_d            = SCAN;
                    search_read_d      = 1'b1;
                    search_read_addr_d = addr_of(rd_col_q, 6'd0);
                    scan_col_d         = rd_col_q;
                    scan_idx_d         = 2'd0;
                    rd_row_d           = 6'd0;
                end
            end
            SCAN: begin
                if (rd_row_q == LAST_ROW) begin
                    if (scan_idx_q == LAST_COL_IDX) begin
                        state_d     = DONE;
                        scan_done_d = 1'b1;
                    end else begin
                        search_read_d      = 1'b1;
                        scan_col_d         = col_inc(scan_col_q);
                        scan_idx_d         = scan_idx_q + 2'd1;
                        rd_row_d           = 6'd0;
                        search_read_addr_d = addr_of(col_inc(scan_col_q), 6'd0);
                    end
                end else begin
                    search_read_d      = 1'b1;
                    rd_row_d           = rd_row_q + 6'd1;
                    search_read_addr_d = addr_of(scan_col_q, rd_row_q + 6'd1);
                end
            end
            DONE: begin
                state_d     = IDLE;
                rd_col_d    = col_inc(rd_col_q);
                col_release = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        scan_busy_d = (state_d != IDLE);

        case ({col_done, col_release})
            2'b10:   col_count_d = col_count_q + 2'd1;
            2'b01:   col_count_d = col_count_q - 2'd1;
            default: col_count_d = col_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            wr_col_q            <= 2'd0;
            wr_row_q            <= 6'd0;
            rd_col_q            <= 2'd0;
            scan_col_q          <= 2'd0;
            scan_idx_q          <= 2'd0;
            rd_row_q            <= 6'd0;
            col_count_q         <= 2'd0;
            scan_busy_q         <= 1'b0;
            scan_valid_q        <= 1'b0;
            scan_row_q          <= 6'd0;
            scan_done_q         <= 1'b0;
            search_read_q       <= 1'b0;
            search_read_addr_q  <= '0;
            search_write_q      <= 1'b0;
            search_write_addr_q <= '0;
            search_write_data_q <= 8'd0;
        end else begin
            state_q             <= state_d;
            wr_col_q            <= wr_col_d;
            wr_row_q            <= wr_row_d;
            rd_col_q            <= rd_col_d;
            scan_col_q          <= scan_col_d;
            scan_idx_q          <= scan_idx_d;
            rd_row_q            <= rd_row_d;
            col_count_q         <= col_count_d;
            scan_busy_q         <= scan_busy_d;
            scan_valid_q        <= scan_valid_d;
            scan_row_q          <= scan_row_d;
            scan_done_q         <= scan_done_d;
            search_read_q       <= search_read_d;
            search_read_addr_q  <= search_read_addr_d;
            search_write_q      <= search_write_d;
            search_write_addr_q <= search_write_addr_d;
            search_write_data_q <= search_write_data_d;
        end
    end

    assign scan_busy         = scan_busy_q;
    assign scan_valid        = scan_valid_q;
    assign scan_row          = scan_row_q;
    assign scan_done         = scan_done_q;
    assign col_count         = col_count_q;
    assign search_read       = search_read_q;
    assign search_read_addr  = search_read_addr_q;
    assign search_write      = search_write_q;
    assign search_write_addr = search_write_addr_q;
    assign search_write_data = search_write_data_q;

endmodule

// File: tb/tb_me_search_window_ctrl.sv
// Bench for me_search_window_ctrl: step table of fills/scans plus reset and concurrency sequences.
// Latency: checks are cycle-exact against the documented read/write timing.
// Backpressure: exercises pix_ready deassertion at 3 filled columns; ME_SEARCH_SLIDE_EN selects the sliding-window table.
module tb_me_search_window_ctrl;

    localparam int ROWS   = 47;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 3 * ROWS;
`ifdef ME_SEARCH_SLIDE_EN
    localparam int NREAD    = 3 * ROWS;
    localparam int FULL_PIX = 3 * ROWS;
    localparam int FULL_CNT = 3;
`else
    localparam int NREAD    = ROWS;
    localparam int FULL_PIX = ROWS;
    localparam int FULL_CNT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic [7:0]        pix_data = 8'd0;
    logic              pix_ready;
    logic              scan_start = 1'b0;
    logic              scan_busy, scan_valid, scan_done;
    logic [5:0]        scan_row;
    logic [1:0]        col_count;
    logic              search_read, search_write;
    logic [ADDR_W-1:0] search_read_addr, search_write_addr;
    logic [7:0]        search_write_data;

    logic [7:0] buf_mem [0:255];
    logic [7:0] buf_rd = 8'd0;
    int         exp_mem [0:255];
    int         nvec = 0;
    int         nerr = 0;

    me_search_window_ctrl #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
        .scan_row(scan_row), .scan_done(scan_done), .col_count(col_count),
        .search_read(search_read), .search_read_addr(search_read_addr),
        .search_write(search_write), .search_write_addr(search_write_addr),
        .search_write_data(search_write_data)
    );

    always #5 clk = ~clk;

    // Behavioural model of the external buffer: synchronous write, registered read.
    always @(posedge clk) begin
        if (search_write) buf_mem[search_write_addr] <= search_write_data;
        if (search_read)  buf_rd <= buf_mem[search_read_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // All tasks start and end at a falling edge, where inputs for the current cycle are driven.
    task automatic no_scan();
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ignored_scan", {search_read, scan_busy}, 2'b00);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        scan_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs",
              {pix_ready, scan_busy, scan_valid, scan_row, scan_done, col_count, search_read,
               search_read_addr, search_write, search_write_addr, search_write_data},
              {1'b1, 37'd0});
        no_scan();
    endtask

    task automatic fill(input int n, input int base, input int wr0, input int cnt_after);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(base + i);
            exp_mem[(wr0 + i) % DEPTH] = (base + i) & 8'hff;
            @(negedge clk);
            check("write", {search_write, search_write_addr, search_write_data},
                  {1'b1, ADDR_W'((wr0 + i) % DEPTH), 8'(base + i)});
        end
        pix_valid = 1'b0;
        check("cnt_fill", col_count, cnt_after);
    endtask

    task automatic bp_probe();
        check("pix_ready_full", pix_ready, 1'b0);
        pix_valid = 1'b1;
        pix_data  = 8'hee;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {search_write, col_count}, {1'b0, 2'd3});
        end
        pix_valid = 1'b0;
    endtask

    task automatic scan(input int rd0, input int cnt_after);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int c = 1; c <= NREAD + 2; c++) begin
            check("scan_flags", {search_read, scan_valid, scan_done, scan_busy},
                  {c <= NREAD, (c >= 2) && (c <= NREAD + 1), c == NREAD + 1, c <= NREAD + 1});
            if (c <= NREAD)
                check("scan_addr", search_read_addr, (rd0 + c - 1) % DEPTH);
            if ((c >= 2) && (c <= NREAD + 1)) begin
                check("scan_row", scan_row, (c - 2) % ROWS);
                check("scan_data", buf_rd, exp_mem[(rd0 + c - 2) % DEPTH]);
            end
            if (c == NREAD + 2)
                check("cnt_release", col_count, cnt_after);
            else
                @(negedge clk);
        end
    endtask

    typedef struct {
        bit rst;
        bit ign;
        int npix;
        int base;
        int wr0;
        int cnt_fill;
        bit bp;
        bit conc;
        bit scn;
        int rd0;
        int cnt_scan;
    } vec_t;

    function automatic vec_t mk(bit rst, bit ign, int npix, int base, int wr0, int cnt_fill,
                                bit bp, bit conc, bit scn, int rd0, int cnt_scan);
        vec_t v;
        v.rst = rst; v.ign = ign; v.npix = npix; v.base = base; v.wr0 = wr0;
        v.cnt_fill = cnt_fill; v.bp = bp; v.conc = conc; v.scn = scn;
        v.rd0 = rd0; v.cnt_scan = cnt_scan;
        return v;
    endfunction

    vec_t tbl [0:7];
    int   ntbl;
    vec_t v;

    initial begin
`ifdef ME_SEARCH_SLIDE_EN
        tbl[0] = mk(1, 0, 141,   0,  0, 3, 1, 0, 0,  0, 0);
        tbl[1] = mk(0, 0,   0,   0,  0, 0, 0, 0, 1,  0, 2);
        tbl[2] = mk(0, 1,  47, 200,  0, 3, 0, 0, 1, 47, 2);
        ntbl = 3;
`else
        // Columns filled/scanned in order, including a pointer wrap and a release
        // landing in the same cycle as a column completion.
        tbl[0] = mk(1, 0,  47,   0,  0, 1, 0, 0, 1,  0, 0);
        tbl[1] = mk(1, 0, 141, 100,  0, 3, 1, 0, 0,  0, 0);
        tbl[2] = mk(0, 0,   0,   0,  0, 0, 0, 0, 1,  0, 2);
        tbl[3] = mk(0, 0,  47,  50,  0, 3, 0, 0, 1, 47, 2);
        tbl[4] = mk(0, 0,  47,  10, 47, 2, 0, 1, 1, 94, 2);
        tbl[5] = mk(0, 0,   0,   0,  0, 0, 0, 0, 1,  0, 1);
        tbl[6] = mk(0, 0,   0,   0,  0, 0, 0, 0, 1, 47, 0);
        ntbl = 7;
`endif
        @(negedge clk);
        for (int i = 0; i < ntbl; i++) begin
            v = tbl[i];
            if (v.rst) do_reset();
            if (v.ign) no_scan();
            if (v.conc) begin
                fork
                    scan(v.rd0, v.cnt_scan);
                    begin
                        repeat (2) @(negedge clk);
                        fill(v.npix, v.base, v.wr0, v.cnt_fill);
                    end
                join
            end else begin
                if (v.npix > 0) fill(v.npix, v.base, v.wr0, v.cnt_fill);
                if (v.bp) bp_probe();
                if (v.scn) scan(v.rd0, v.cnt_scan);
            end
        end

        // Asynchronous reset while row 20 is being read.
        do_reset();
        fill(FULL_PIX, 5, 0, FULL_CNT);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (20) @(negedge clk);
        check("midscan_addr", {search_read, search_read_addr}, {1'b1, ADDR_W'(20)});
        rst_n = 1'b0;
        #1;
        check("midscan_reset", {search_read, scan_valid, scan_busy, col_count, pix_ready},
              {3'b000, 2'd0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        no_scan();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
